// File: rtl/pq_dispatch.sv
// Client-side controller for the two-heap priority queue: arbitrates inserts and
// extractions, enforces operation spacing, and buffers dequeued events for the consumer.
module pq_dispatch #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 8,
   parameter int OP_GAP = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             new_vld,
   input  logic [WIDTH-1:0] new_data,
   output logic             new_rdy,
   output logic             evt_vld,
   output logic [WIDTH-1:0] evt_data,
   input  logic             evt_rdy,
   output logic             q_enq,
   output logic             q_deq,
   output logic [WIDTH-1:0] q_inp_data,
   input  logic [WIDTH-1:0] q_out_data,
   input  logic [DEPTH:0]   q_elem_cnt,
   input  logic             q_full,
   input  logic             q_empty,
   output logic [DEPTH+1:0] in_flight
);

   localparam int GW = (OP_GAP > 0) ? $clog2(OP_GAP + 1) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(OP_GAP);

   logic [GW-1:0]    gap_cnt;
   logic             last;
   logic [1:0]       buf_cnt;
   logic [WIDTH-1:0] slot0;
   logic [WIDTH-1:0] slot1;
   logic             idle;
   logic             enq_ok;
   logic             deq_ok;
   logic             grant_enq;
   logic             grant_deq;
   logic             push;
   logic             pop;

   assign idle   = (gap_cnt == '0);
   assign enq_ok = idle & new_vld & ~q_full;
   assign deq_ok = idle & ~q_empty & (buf_cnt < 2'd2);

   // Grants are gated by rst_n so nothing reaches the queue while reset is held.
   assign grant_enq = rst_n & enq_ok & (~deq_ok | last);
   assign grant_deq = rst_n & deq_ok & (~enq_ok | ~last);

   assign q_enq      = grant_enq;
   assign q_deq      = grant_deq;
   assign new_rdy    = grant_enq;
   assign q_inp_data = new_data;

   assign push     = grant_deq;
   assign pop      = evt_vld & evt_rdy;
   assign evt_vld  = (buf_cnt != 2'd0);
   assign evt_data = slot0;

   assign in_flight = {1'b0, q_elem_cnt} + {{DEPTH{1'b0}}, buf_cnt};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gap_cnt <= '0;
         last    <= 1'b1;
      end else if (grant_enq | grant_deq) begin
         gap_cnt <= GAP_LOAD;
         last    <= grant_deq;
      end else if (!idle) begin
         gap_cnt <= gap_cnt - 1'b1;
      end
   end

   // slot0 is always the oldest entry; push+pop only occurs with one entry held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_cnt <= '0;
         slot0   <= '0;
         slot1   <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (buf_cnt == 2'd0) slot0 <= q_out_data;
               else                 slot1 <= q_out_data;
               buf_cnt <= buf_cnt + 2'd1;
            end
            2'b01: begin
               slot0   <= slot1;
               buf_cnt <= buf_cnt - 2'd1;
            end
            2'b11: slot0 <= q_out_data;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pq_dispatch.sv
// Directed bench for pq_dispatch: one instance (OP_GAP=1) against a behavioural
// min-queue, one instance (OP_GAP=0) with directly driven queue status.
module tb_pq_dispatch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instance A: OP_GAP=1 with queue model
   logic        a_rst_n, a_new_vld, a_new_rdy, a_evt_vld, a_evt_rdy, a_q_enq, a_q_deq, a_q_full, a_q_empty;
   logic [31:0] a_new_data, a_evt_data, a_q_inp_data, a_q_out_data;
   logic [8:0]  a_q_elem_cnt;
   logic [9:0]  a_in_flight;

   // Instance B: OP_GAP=0 with directed queue status
   logic        b_rst_n, b_new_vld, b_new_rdy, b_evt_vld, b_evt_rdy, b_q_enq, b_q_deq, b_q_full, b_q_empty;
   logic [31:0] b_new_data, b_evt_data, b_q_inp_data, b_q_out_data;
   logic [8:0]  b_q_elem_cnt;
   logic [9:0]  b_in_flight;

   pq_dispatch #(.WIDTH(32), .DEPTH(8), .OP_GAP(1)) dut_a (
      .clk(clk), .rst_n(a_rst_n), .new_vld(a_new_vld), .new_data(a_new_data), .new_rdy(a_new_rdy),
      .evt_vld(a_evt_vld), .evt_data(a_evt_data), .evt_rdy(a_evt_rdy), .q_enq(a_q_enq), .q_deq(a_q_deq),
      .q_inp_data(a_q_inp_data), .q_out_data(a_q_out_data), .q_elem_cnt(a_q_elem_cnt),
      .q_full(a_q_full), .q_empty(a_q_empty), .in_flight(a_in_flight)
   );

   pq_dispatch #(.WIDTH(32), .DEPTH(8), .OP_GAP(0)) dut_b (
      .clk(clk), .rst_n(b_rst_n), .new_vld(b_new_vld), .new_data(b_new_data), .new_rdy(b_new_rdy),
      .evt_vld(b_evt_vld), .evt_data(b_evt_data), .evt_rdy(b_evt_rdy), .q_enq(b_q_enq), .q_deq(b_q_deq),
      .q_inp_data(b_q_inp_data), .q_out_data(b_q_out_data), .q_elem_cnt(b_q_elem_cnt),
      .q_full(b_q_full), .q_empty(b_q_empty), .in_flight(b_in_flight)
   );

   // Behavioural min-queue: unsorted storage, head is the smallest entry.
   logic [31:0] qm [16] = '{default: '0};
   int          qn = 0;
   int          mi;
   logic [31:0] qmin;

   always_comb begin
      mi   = 0;
      qmin = '1;
      for (int i = 0; i < 16; i++)
         if (i < qn && qm[i] < qmin) begin
            qmin = qm[i];
            mi   = i;
         end
   end

   assign a_q_out_data = qmin;
   assign a_q_empty    = (qn == 0);
   assign a_q_full     = (qn == 16);
   assign a_q_elem_cnt = 9'(qn);

   always @(posedge clk) begin
      if (a_q_enq) begin
         qm[qn] <= a_q_inp_data;
         qn     <= qn + 1;
      end else if (a_q_deq) begin
         qm[mi] <= qm[qn-1];
         qn     <= qn - 1;
      end
   end

   logic [31:0] pend[$];
   logic        a_acc;
   logic        a_rdy_nxt;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle of instance A: drive producer/consumer after the edge, check grants mid-cycle.
   task automatic a_step(input logic ee, input logic ed, input string tag);
      @(posedge clk);
      #1;
      if (a_acc) pend.delete(0);
      a_evt_rdy  = a_rdy_nxt;
      a_new_vld  = (pend.size() != 0);
      a_new_data = (pend.size() != 0) ? pend[0] : 32'h0;
      @(negedge clk);
      chk({tag, ".enq"}, {63'd0, a_q_enq}, {63'd0, ee});
      chk({tag, ".deq"}, {63'd0, a_q_deq}, {63'd0, ed});
      a_acc = a_q_enq;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      a_rst_n = 1'b0; b_rst_n = 1'b0;
      pend = '{32'h05, 32'h06};
      a_new_vld = 1'b1; a_new_data = 32'h05; a_evt_rdy = 1'b0; a_rdy_nxt = 1'b0; a_acc = 1'b0;
      b_new_vld = 1'b1; b_new_data = 32'h55; b_evt_rdy = 1'b1; b_q_full = 1'b0; b_q_empty = 1'b0;
      b_q_elem_cnt = 9'd4; b_q_out_data = 32'hAB;

      @(negedge clk);
      chk("rst.a_evt_vld",   {63'd0, a_evt_vld}, 64'd0);
      chk("rst.a_q_enq",     {63'd0, a_q_enq}, 64'd0);
      chk("rst.a_new_rdy",   {63'd0, a_new_rdy}, 64'd0);
      chk("rst.a_in_flight", {54'd0, a_in_flight}, 64'd0);
      chk("rst.b_evt_vld",   {63'd0, b_evt_vld}, 64'd0);
      chk("rst.b_q_enq",     {63'd0, b_q_enq}, 64'd0);
      chk("rst.b_q_deq",     {63'd0, b_q_deq}, 64'd0);
      chk("rst.b_in_flight", {54'd0, b_in_flight}, 64'd4);
      a_new_vld = 1'b0;
      @(posedge clk);
      #1 a_rst_n = 1'b1;

      // Fill the output buffer with 0x05, 0x06 via alternating grants
      a_step(1, 0, "c0");
      a_step(0, 0, "c1");
      a_step(0, 1, "c2");
      a_step(0, 0, "c3");
      chk("c3.evt_vld",  {63'd0, a_evt_vld}, 64'd1);
      chk("c3.evt_data", {32'd0, a_evt_data}, 64'h05);
      a_step(1, 0, "c4");
      a_step(0, 0, "c5");
      a_step(0, 1, "c6");
      // Buffer full: inserts 0x30, 0x10, 0x20 go through unopposed every other cycle
      pend = '{32'h30, 32'h10, 32'h20};
      a_step(0, 0, "c7");
      a_step(1, 0, "c8");
      a_step(0, 0, "c9");
      a_step(1, 0, "c10");
      a_step(0, 0, "c11");
      a_step(1, 0, "c12");
      a_step(0, 0, "c13");
      chk("c13.in_flight", {54'd0, a_in_flight}, 64'd5);
      chk("c13.evt_data",  {32'd0, a_evt_data}, 64'h05);
      a_rdy_nxt = 1'b1;
      // Pop with full buffer does not allow a deq in the same cycle
      a_step(0, 0, "c14");
      chk("c14.evt_data", {32'd0, a_evt_data}, 64'h05);
      a_step(0, 1, "c15");
      chk("c15.evt_data", {32'd0, a_evt_data}, 64'h06);
      a_step(0, 0, "c16");
      chk("c16.evt_data", {32'd0, a_evt_data}, 64'h10);
      a_step(0, 1, "c17");
      chk("c17.evt_vld",  {63'd0, a_evt_vld}, 64'd0);
      a_step(0, 0, "c18");
      chk("c18.evt_data", {32'd0, a_evt_data}, 64'h20);
      a_step(0, 1, "c19");
      chk("c19.evt_vld",  {63'd0, a_evt_vld}, 64'd0);
      a_step(0, 0, "c20");
      chk("c20.evt_data", {32'd0, a_evt_data}, 64'h30);
      a_step(0, 0, "c21");
      chk("c21.evt_vld",   {63'd0, a_evt_vld}, 64'd0);
      chk("c21.in_flight", {54'd0, a_in_flight}, 64'd0);

      // Reset mid-gap with a full buffer
      a_rdy_nxt = 1'b0;
      pend = '{32'h60, 32'h61, 32'h62};
      a_step(1, 0, "c22");
      a_step(0, 0, "c23");
      a_step(0, 1, "c24");
      a_step(0, 0, "c25");
      a_step(1, 0, "c26");
      a_step(0, 0, "c27");
      a_step(0, 1, "c28");
      a_step(0, 0, "c29");
      a_step(1, 0, "c30");
      a_step(0, 0, "c31");
      chk("c31.evt_vld",   {63'd0, a_evt_vld}, 64'd1);
      chk("c31.in_flight", {54'd0, a_in_flight}, 64'd3);
      a_rst_n = 1'b0;
      #1;
      chk("rst2.evt_vld",   {63'd0, a_evt_vld}, 64'd0);
      chk("rst2.in_flight", {54'd0, a_in_flight}, 64'd1);
      pend.delete();
      pend.push_back(32'h63);
      a_new_vld = 1'b1; a_new_data = 32'h63; a_acc = 1'b0;
      #1;
      chk("rst2.q_enq", {63'd0, a_q_enq}, 64'd0);
      @(posedge clk);
      #1 a_rst_n = 1'b1;
      @(negedge clk);
      chk("c32.enq", {63'd0, a_q_enq}, 64'd1);
      chk("c32.deq", {63'd0, a_q_deq}, 64'd0);
      a_acc = a_q_enq;
      a_step(0, 0, "c33");
      a_step(0, 1, "c34");

      // Instance B: sustained contention alternates starting with enq
      @(posedge clk);
      #1 b_rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("alt.enq", {63'd0, b_q_enq}, {63'd0, (i % 2) == 0});
         chk("alt.deq", {63'd0, b_q_deq}, {63'd0, (i % 2) == 1});
         if (i == 0) begin
            chk("alt.new_rdy",    {63'd0, b_new_rdy}, 64'd1);
            chk("alt.q_inp_data", {32'd0, b_q_inp_data}, 64'h55);
         end
         if (i == 2) begin
            chk("alt.evt_data",  {32'd0, b_evt_data}, 64'hAB);
            chk("alt.in_flight", {54'd0, b_in_flight}, 64'd5);
         end
         @(posedge clk);
         #1;
      end

      b_q_empty = 1'b1;
      @(negedge clk);
      chk("empty.enq", {63'd0, b_q_enq}, 64'd1);
      chk("empty.deq", {63'd0, b_q_deq}, 64'd0);
      @(posedge clk);
      #1;

      // Consumer stalled: exactly two deqs fill the buffer
      b_q_empty = 1'b0; b_new_vld = 1'b0; b_evt_rdy = 1'b0; b_q_out_data = 32'hC1;
      @(negedge clk);
      chk("bf.j0.deq", {63'd0, b_q_deq}, 64'd1);
      @(posedge clk);
      #1 b_q_out_data = 32'hC2;
      @(negedge clk);
      chk("bf.j1.deq", {63'd0, b_q_deq}, 64'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bf.j2.deq",       {63'd0, b_q_deq}, 64'd0);
      chk("bf.j2.evt_data",  {32'd0, b_evt_data}, 64'hC1);
      chk("bf.j2.in_flight", {54'd0, b_in_flight}, 64'd6);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bf.j3.deq", {63'd0, b_q_deq}, 64'd0);
      @(posedge clk);
      #1 b_evt_rdy = 1'b1;
      @(negedge clk);
      chk("bf.j4.deq", {63'd0, b_q_deq}, 64'd0);
      @(posedge clk);
      #1 b_evt_rdy = 1'b0;
      @(negedge clk);
      chk("bf.j5.deq",      {63'd0, b_q_deq}, 64'd1);
      chk("bf.j5.evt_data", {32'd0, b_evt_data}, 64'hC2);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bf.j6.deq", {63'd0, b_q_deq}, 64'd0);
      @(posedge clk);
      #1;

      // Queue full: inserts blocked, deqs continue once the buffer drains
      b_q_full = 1'b1; b_new_vld = 1'b1; b_new_data = 32'h99; b_evt_rdy = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("full.new_rdy",    {63'd0, b_new_rdy}, 64'd0);
         chk("full.deq",        {63'd0, b_q_deq}, {63'd0, k != 0});
         chk("full.q_inp_data", {32'd0, b_q_inp_data}, 64'h99);
         @(posedge clk);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pq_dispatch.md
# pq_dispatch

Client-side controller for the two-heap priority queue in the PDES event path. It accepts new events from a producer through a valid/ready handshake and pulls the minimum-timestamp event out of the queue. Dequeued events are delivered to the consumer (core scheduler) through a 2-entry output buffer. It drives the queue's `enq`/`deq`/`inp_data` pins, honours `full`/`empty` and a minimum spacing between queue operations, and arbitrates fairly between insertion and extraction.

## Interface
Parameters:
- `WIDTH`, 32: event word width; must equal the queue's `WIDTH`.
- `DEPTH`, 8: per-heap depth; must equal the queue's `DEPTH`. `q_elem_cnt` is DEPTH+1 bits.
- `OP_GAP`, 1: idle cycles forced after every queue operation. 0 allows back-to-back operations.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `new_vld`  in  1  producer has an event to insert.
- `new_data`  in  WIDTH  event to insert; held stable while `new_vld` is high and `new_rdy` is low.
- `new_rdy`  out  1  combinational; high in the cycle the insert is issued to the queue.
- `evt_vld`  out  1  output buffer holds at least one event.
- `evt_data`  out  WIDTH  oldest event in the output buffer.
- `evt_rdy`  in  1  consumer accepts `evt_data` this cycle.
- `q_enq`  out  1  enqueue pulse to the queue.
- `q_deq`  out  1  dequeue pulse to the queue.
- `q_inp_data`  out  WIDTH  equals `new_data`.
- `q_out_data`  in  WIDTH  queue head; combinational and valid while `q_empty` is low.
- `q_elem_cnt`  in  DEPTH+1  queue occupancy.
- `q_full`  in  1  queue cannot accept an insert.
- `q_empty`  in  1  queue holds no events.
- `in_flight`  out  DEPTH+2  `q_elem_cnt` plus the buffer count, zero-extended sum.

## Operation
- Gap counter `gap_cnt`, width max(1, clog2(OP_GAP+1)).
  - Loaded with OP_GAP on every issued operation.
  - Otherwise decrements to 0 and saturates there.
  - `idle` = (gap_cnt == 0).
- Eligibility:
  - enq_ok = `idle` & `new_vld` & ~`q_full`.
  - deq_ok = `idle` & ~`q_empty` & (buf_cnt < 2).
- Arbitration uses a 1-bit register `last`: 0 = last grant was enq, 1 = last grant was deq. Reset value is 1, so enq wins the first tie.
  - Only one of enq_ok/deq_ok set: grant it.
  - Both set: grant enq if `last`=1, otherwise grant deq.
  - `last` updates only when a grant is issued.
- At most one of `q_enq`/`q_deq` is high in any cycle. Both are combinational grants and are never registered.
- `new_rdy` = `q_enq`.
- Deq capture: in the `q_deq` cycle, `q_out_data` is written into the output buffer at the edge ending that cycle.
- Output buffer: 2-entry FIFO with `buf_cnt` 0..2.
  - Push = `q_deq`. Pop = `evt_vld` & `evt_rdy`.
  - Simultaneous push and pop: count unchanged, ordering preserved.
  - Pop on empty is ignored.
- `in_flight` is combinational from `q_elem_cnt` and `buf_cnt`.

## Timing
- Reset (asynchronous, any cycle, including mid-gap or with a full buffer):
  - `gap_cnt`=0, `buf_cnt`=0, `last`=1.
  - Buffer contents are don't-care.
  - `evt_vld`=0, `new_rdy`/`q_enq`/`q_deq`=0 while reset is asserted, `in_flight`=`q_elem_cnt`.
- Insert latency: a `new_vld` arriving when `idle` and the queue is not full is granted in the same cycle (0 cycles), subject to arbitration.
- Deq-to-consumer latency: `evt_vld` rises 1 cycle after the `q_deq` cycle.
- Operation spacing: after an operation in cycle t, the next operation issues no earlier than cycle t+OP_GAP+1.
- Full buffer: deq is suppressed even if the consumer pops in the same cycle. Deq resumes the cycle after `buf_cnt` drops below 2.
- Queue full: `new_rdy` stays low and deqs continue to be issued.
- Queue empty: only enqs are issued.
- Sustained contention with OP_GAP=0: grants alternate enq, deq, enq, …, and each side gets a 50% share.

## Test plan
- Reset, then with OP_GAP=1 insert 0x30, 0x10, 0x20 (consumer held off by `evt_rdy`=0): `q_enq` fires in cycles 0, 2, 4; `in_flight`=3.
- Continue with `evt_rdy`=1, no inserts: events 0x10, 0x20, 0x30 are delivered in order; each `evt_vld` is 1 cycle after its `q_deq`; `q_deq` spacing is 2 cycles; `in_flight` ends at 0.
- OP_GAP=0, `new_vld` held high, queue holds 4 events, `evt_rdy`=1: `q_enq`/`q_deq` strictly alternate starting with enq; never both high.
- `evt_rdy`=0 with queue holding 5: exactly 2 deqs, then `buf_cnt`=2 and no further `q_deq`. Raise `evt_rdy` for 1 cycle: next `q_deq` occurs the following cycle.
- `q_full`=1 with `new_vld`=1: `new_rdy` stays 0 for 10 cycles, deqs proceed, and `new_data` is held.
- Assert `rst_n`=0 mid-gap with `buf_cnt`=2: `evt_vld` drops immediately; after release, the first tie grants enq.
